// File: rtl/ir_sequencer.sv
// Instruction-issue sequencer for the MIPS_uP IR/p interface: buffers host instructions,
// holds each on IR for a fixed execution window, then returns the sampled p with a handshake.
module ir_sequencer #(
  parameter int INS_WIDTH = 32,
  parameter int ALU_WIDTH = 37,
  parameter int DEPTH = 8,
  parameter int EXEC_CYCLES = 4,
  parameter logic [INS_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INS_WIDTH-1:0] ins_data,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [INS_WIDTH-1:0] IR,
  input  logic [ALU_WIDTH-1:0] p,
  output logic [ALU_WIDTH-1:0] res_data,
  output logic [7:0]           res_tag,
  output logic                 res_valid,
  input  logic                 res_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESULT} state_t;

  state_t state, state_nxt;

  logic [INS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, push, pop;
  logic                 capture, take;
  logic [CW-1:0]        exec_cnt;
  logic [7:0]           tag_ctr, cur_tag;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign ins_ready = !full;
  assign push      = ins_valid && ins_ready;

  // Instruction FIFO: storage carries no reset, only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ins_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = EXEC;
      EXEC:    if (exec_cnt == '0) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    pop     = (state == ISSUE);
    capture = (state == EXEC) && (exec_cnt == '0);
    take    = (state == RESULT) && res_ready;
  end

  // Issue / execute / result registers; tag is latched at issue and published at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR        <= NOP_WORD;
      res_data  <= '0;
      res_tag   <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      exec_cnt  <= '0;
      tag_ctr   <= '0;
      cur_tag   <= '0;
    end else begin
      done <= take && empty;
      if (pop) begin
        IR       <= mem[rd_ptr];
        cur_tag  <= tag_ctr;
        tag_ctr  <= tag_ctr + 1'b1;
        exec_cnt <= EXEC_LOAD;
      end else if (capture) begin
        res_data  <= p;
        res_tag   <= cur_tag;
        res_valid <= 1'b1;
        IR        <= NOP_WORD;
      end else if (state == EXEC) begin
        exec_cnt <= exec_cnt - 1'b1;
      end
      if (take) res_valid <= 1'b0;
    end
  end

endmodule
